coin_pulse_conditioner: RTL

Front-end stage that feeds the vending-machine FSM its N and D coin inputs. It takes raw, asynchronous, bouncy nickel/dime sensor lines and synchronises and debounces them. It converts each physical coin insertion into exactly one single-cycle N or D pulse. Simultaneous coins are serialised so the downstream FSM, which gives D priority and does not count both coins in one cycle, never loses a coin; coins arriving while acceptance is disabled are diverted to a reject pulse.

---
 rtl/coin_pulse_conditioner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/coin_pulse_conditioner.sv
// Coin sensor front end for the vending-machine FSM.
// It synchronises and debounces the raw nickel and dime sensor lines.
// Each debounced rising edge becomes exactly one single-cycle N, D or reject pulse.
// Simultaneous coins are serialised: dime first, then nickel on the next cycle.
module coin_pulse_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int CW       = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       accept_en,
  output logic       N,
  output logic       D,
  output logic       reject,
  output logic [7:0] coin_count
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  // Channel index 0 = nickel, 1 = dime.
  logic [1:0]    meta_q, sync_q;
  logic [1:0]    filt_q, filt_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    ev;

  logic          pend_n_q, pend_n_d, pend_d_q, pend_d_d;
  logic          sel_n, sel_d, take_ev_n, take_ev_d;

  logic          n_q, n_d, d_q, d_d, rej_q, rej_d;
  logic [7:0]    count_q, count_d;

  // Two-flop synchroniser on both raw sensor lines.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {dime_raw, nickel_raw};
      sync_q <= meta_q;
    end
  end

  // Debounce filter. The filtered value only follows the synchronised input
  // after DEBOUNCE consecutive mismatching cycles. A coin event is the cycle
  // in which the filtered value is about to go 0->1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      ev[i]     = 1'b0;
      if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
        ev[i]     = sync_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Arbitration order: pending dime, pending nickel, new dime, new nickel.
  // A new event that loses arbitration is parked in its pending flag.
  always_comb begin
    sel_n     = 1'b0;
    sel_d     = 1'b0;
    take_ev_n = 1'b0;
    take_ev_d = 1'b0;
    pend_n_d  = pend_n_q;
    pend_d_d  = pend_d_q;
    if (pend_d_q) begin
      sel_d    = 1'b1;
      pend_d_d = 1'b0;
    end else if (pend_n_q) begin
      sel_n    = 1'b1;
      pend_n_d = 1'b0;
    end else if (ev[1]) begin
      sel_d     = 1'b1;
      take_ev_d = 1'b1;
    end else if (ev[0]) begin
      sel_n     = 1'b1;
      take_ev_n = 1'b1;
    end
    if (ev[1] && !take_ev_d) pend_d_d = 1'b1;
    if (ev[0] && !take_ev_n) pend_n_d = 1'b1;
  end

  // Output pulse decode and saturating count of forwarded coins.
  always_comb begin
    n_d     = sel_n & accept_en;
    d_d     = sel_d & accept_en;
    rej_d   = (sel_n | sel_d) & ~accept_en;
    count_d = count_q;
    if ((n_d || d_d) && (count_q != 8'hFF)) count_d = count_q + 8'd1;
  end

  // Filter, arbitration and output state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      filt_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      pend_n_q <= 1'b0;
      pend_d_q <= 1'b0;
      n_q      <= 1'b0;
      d_q      <= 1'b0;
      rej_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      pend_n_q <= pend_n_d;
      pend_d_q <= pend_d_d;
      n_q      <= n_d;
      d_q      <= d_d;
      rej_q    <= rej_d;
      count_q  <= count_d;
    end
  end

  assign N          = n_q;
  assign D          = d_q;
  assign reject     = rej_q;
  assign coin_count = count_q;

endmodule
